// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with 8 ops, guarded accumulator and status flags.
// Optional clamping arithmetic is enabled by defining ALU_PIPE_SATURATE_EN.
module alu_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_GUARD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             dz
);

  localparam int unsigned AW = WIDTH + ACC_GUARD;
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  // Stage 1: captured command
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_cmd_q, s1_cmd_d;
  logic             s1_clr_q, s1_clr_d;

  // Stage 2: result, flags and accumulator
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic [AW-1:0]    acc_q, acc_d;

  logic adv;

  // Datapath intermediates
  logic [2:0]       op;
  logic             acc_mode;
  logic [WIDTH:0]   sum_w;
  logic [PW-1:0]    prod_w;
  logic [WIDTH-1:0] op_res;
  logic             ovf_op;
  logic             dz_op;
  logic [AW-1:0]    acc_base;
  logic [AW:0]      acc_sum;
  logic [AW-1:0]    acc_next;
  logic             acc_big;
  logic [WIDTH-1:0] acc_res;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = adv || !s1_valid_q;

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // Opcode evaluation on the stage-1 operands
  always_comb begin
    op       = s1_cmd_q[2:0];
    acc_mode = s1_cmd_q[3];
    sum_w    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    prod_w   = PW'(s1_a_q) * PW'(s1_b_q);
    op_res   = '0;
    ovf_op   = 1'b0;
    dz_op    = 1'b0;
    case (op)
      3'd0: begin
        ovf_op = sum_w[WIDTH];
`ifdef ALU_PIPE_SATURATE_EN
        op_res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
        op_res = sum_w[WIDTH-1:0];
`endif
      end
      3'd1: begin
        ovf_op = s1_a_q < s1_b_q;
`ifdef ALU_PIPE_SATURATE_EN
        op_res = ovf_op ? '0 : WIDTH'(s1_a_q - s1_b_q);
`else
        op_res = WIDTH'(s1_a_q - s1_b_q);
`endif
      end
      3'd2: begin
        ovf_op = |prod_w[PW-1:WIDTH];
`ifdef ALU_PIPE_SATURATE_EN
        op_res = ovf_op ? '1 : prod_w[WIDTH-1:0];
`else
        op_res = prod_w[WIDTH-1:0];
`endif
      end
      3'd3: begin
        dz_op  = s1_b_q == '0;
        op_res = dz_op ? '0 : WIDTH'(s1_a_q % s1_b_q);
      end
      3'd4: op_res = s1_a_q | s1_b_q;
      3'd5: op_res = s1_a_q & s1_b_q;
      3'd6: op_res = s1_a_q ^ s1_b_q;
      default: op_res = WIDTH'(s1_a_q << s1_b_q[SW-1:0]);
    endcase
  end

  // Accumulator update; guard bits above WIDTH mark overflow of the result
  always_comb begin
    acc_base = s1_clr_q ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + (AW + 1)'(op_res);
`ifdef ALU_PIPE_SATURATE_EN
    acc_next = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
`else
    acc_next = acc_sum[AW-1:0];
`endif
    acc_big  = |acc_next[AW-1:WIDTH];
`ifdef ALU_PIPE_SATURATE_EN
    acc_res  = acc_big ? '1 : acc_next[WIDTH-1:0];
`else
    acc_res  = acc_next[WIDTH-1:0];
`endif
  end

  // Next-state for both stages under the global stall
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cmd_d   = s1_cmd_q;
    s1_clr_d   = s1_clr_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    acc_d      = acc_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_cmd_d = cmd;
        s1_clr_d = acc_clr;
      end
    end

    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        dz_d = dz_op;
        if (acc_mode) begin
          acc_d    = acc_next;
          result_d = acc_res;
          ovf_d    = ovf_op | acc_big;
        end else begin
          acc_d    = s1_clr_q ? '0 : acc_q;
          result_d = op_res;
          ovf_d    = ovf_op;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cmd_q   <= '0;
      s1_clr_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cmd_q   <= s1_cmd_d;
      s1_clr_q   <= s1_clr_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16, ACC_GUARD=4); expectations follow ALU_PIPE_SATURATE_EN.
module tb_alu_pipe;

`ifdef ALU_PIPE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cmd;
  logic [15:0] a, b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf, dz;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   accepted = 0;
  int   n_out    = 0;
  exp_t sb[$];

  alu_pipe #(.WIDTH(16), .ACC_GUARD(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one command, wait for the handshake, then queue its expectation
  task automatic send(input logic [3:0] c, input logic [15:0] av, input logic [15:0] bv,
                      input logic clr, input logic [15:0] er, input logic eo,
                      input logic ed, input bit chk);
    bit ok;
    exp_t e;
    int cyc;
    in_valid = 1'b1; cmd = c; a = av; b = bv; acc_clr = clr;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never high, cmd=%h", c);
    end else begin
      accepted++;
      if (chk) begin
        e.res = er; e.ovf = eo; e.dz = ed;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every transferred result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        n_tests++;
        n_out++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL out_%0d: unexpected result %h", n_out, result);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || ovf !== e.ovf || dz !== e.dz) begin
            n_fail++;
            $display("FAIL out_%0d: got res=%h ovf=%b dz=%b, expected res=%h ovf=%b dz=%b",
                     n_out, result, ovf, dz, e.res, e.ovf, e.dz);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] held;
    reset = 1'b1; in_valid = 1'b0; cmd = '0; a = '0; b = '0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({ovf, dz}), 32'd0);

    // 1: basic add and 2-cycle latency
    out_ready = 1'b1;
    send(4'd0, 16'd3, 16'd5, 1'b0, 16'd8, 1'b0, 1'b0, 1'b1);
    check("lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2", 32'(out_valid), 32'd1);
    wait_drain("drain_t1");

    // 2: overflow / borrow / multiply, plus logic and shift ops
    send(4'd0, 16'hFFFF, 16'd1, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0, 1'b1);
    send(4'd1, 16'd2, 16'd5, 1'b0, SAT ? 16'h0000 : 16'hFFFD, 1'b1, 1'b0, 1'b1);
    send(4'd2, 16'd300, 16'd300, 1'b0, SAT ? 16'hFFFF : 16'h5F90, 1'b1, 1'b0, 1'b1);
    send(4'd2, 16'h0100, 16'h0010, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(4'd4, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    send(4'd5, 16'hFF00, 16'h0FF0, 1'b0, 16'h0F00, 1'b0, 1'b0, 1'b1);
    send(4'd6, 16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    send(4'd7, 16'h0001, 16'h001F, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    // 3: modulo and divide-by-zero
    send(4'd3, 16'd7, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(4'd3, 16'd7, 16'd3, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_t23");

    // 4: back-to-back accumulate with no bubble
    send(4'd8, 16'd1, 16'd2, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1);
    send(4'd8, 16'd4, 16'd0, 1'b0, 16'd7, 1'b0, 1'b0, 1'b1);
    send(4'd8, 16'd4, 16'd0, 1'b0, 16'd11, 1'b0, 1'b0, 1'b1);
    check("acc_b2b_2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("acc_b2b_3", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("acc_b2b_end", 32'(out_valid), 32'd0);
    // accumulator crossing 2**WIDTH, then explicit clear on a plain op
    send(4'd8, 16'hFFFF, 16'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    send(4'd8, 16'd2, 16'd0, 1'b0, SAT ? 16'hFFFF : 16'h0001, 1'b1, 1'b0, 1'b1);
    send(4'd0, 16'd1, 16'd1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1);
    send(4'd8, 16'd5, 16'd0, 1'b0, 16'd5, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_t4");

    // 5: back-pressure with four commands
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(4'd0, 16'd1, 16'd1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1);
        send(4'd0, 16'd2, 16'd2, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1);
        send(4'd0, 16'd3, 16'd3, 1'b0, 16'd6, 1'b0, 1'b0, 1'b1);
        send(4'd0, 16'd4, 16'd4, 1'b0, 16'd8, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("bp_accepted", 32'(accepted), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = result;
        check("bp_head", 32'(held), 32'd2);
        repeat (3) @(posedge clk);
        #2;
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_stable_res", 32'(result), 32'd2);
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_t5");

    // 6: reset with two accumulates in flight
    out_ready = 1'b0;
    send(4'd8, 16'd100, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    send(4'd8, 16'd100, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(4'd8, 16'd9, 16'd0, 1'b0, 16'd9, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_t6");
    repeat (3) @(posedge clk);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
